sync_up_counter_tff: RTL and testbench
======================================

// Module: sync_up_counter_tff
// PURPOSE
//  Parameterised synchronous binary UP counter built from a T-flip-flop chain
//  (bit i toggles when all lower bits are 1 and the count is enabled).
//  Adds count enable, synchronous parallel load, programmable modulus wrap and
//  a terminal-count strobe for cascading. Serves as the incrementing counterpart
//  to the team's T-FF down counter in timer/divider datapaths.
// PARAMETERS
//  WIDTH    3        counter width in bits (>=1)
//  MOD_VAL  8        modulus; counts 0..MOD_VAL-1; legal 2..2**WIDTH
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      asynchronous, active-low reset
//  en       in   1      count enable; increment by 1 on clk edge when high
//  load     in   1      synchronous parallel load strobe
//  d        in   WIDTH  load value
//  q        out  WIDTH  current count (registered)
//  qb       out  WIDTH  bitwise complement of q (combinational)
//  tc       out  1      terminal count: en & (q == MOD_VAL-1) (combinational)
// BEHAVIOUR
//  - Reset: rst low -> q=0 immediately, no clock needed; qb=all-ones, tc=0.
//    Reset mid-count discards the count; first increment after rst rises
//    occurs on the first clk edge with en=1 (0 -> 1).
//  - Priority per edge: rst (async) > load > en > hold.
//  - load=1: q <= d if d < MOD_VAL, else q <= 0. en ignored that cycle;
//    tc still reflects current q and en.
//  - en=1, load=0: toggle terms T[0]=1, T[i]=&q[i-1:0]; q <= q+1 in one cycle
//    (latency 1 clk). At q==MOD_VAL-1: q <= 0 (synchronous wrap), all bits
//    cleared regardless of toggle terms.
//  - MOD_VAL==2**WIDTH: wrap is natural binary roll-over (all-ones -> 0).
//  - en=0, load=0: q holds.
//  - tc is high exactly in the cycle before wrap; chain stages by feeding tc
//    of stage n into en of stage n+1 (no extra latency).
//  - All arithmetic unsigned, WIDTH bits; no intermediate wider than WIDTH.
//  - q can never reach >= MOD_VAL by any input sequence.
// CONFIGURATION
//  Macro UPCNT_OVF_FLAG_EN:
//   defined   - adds ports: ovf_clr in 1 (sync clear), ovf out 1 (registered).
//               ovf sets on the edge where a wrap occurs (tc=1, load=0) and
//               stays set until ovf_clr=1 or rst low. Same-edge wrap and
//               ovf_clr: set wins (ovf=1). ovf reset value 0.
//   undefined - ports ovf/ovf_clr absent; no flag logic; all else identical.
// TESTING
//  1 rst low mid-count at q=5, en=1 -> q=0 asynchronously before next edge;
//    after release, 8 enabled edges give 1,2,...,7,0 (WIDTH=3, MOD_VAL=8).
//  2 MOD_VAL=6, en=1 continuous from 0 -> q:1,2,3,4,5,0,1; tc=1 only while q=5.
//  3 q=2, load=1, en=1, d=4 -> q=4 next edge; d=7 with MOD_VAL=6 -> q=0.
//  4 en toggled 1,0,0,1 from q=3 -> q=4,4,4,5; qb always ~q.
//  5 Two instances cascaded (tc0->en1), WIDTH=3, MOD_VAL=8: after 64 edges
//    both q=0; upper increments only on lower 7->0 edge.
//  6 UPCNT_OVF_FLAG_EN: wrap 7->0 -> ovf=1; hold 3 edges -> stays 1; ovf_clr=1
//    -> 0; ovf_clr=1 on a wrap edge -> ovf=1.

Source files
------------

// File: rtl/sync_up_counter_tff.sv
// ---------------------------------------------------------------------------
// sync_up_counter_tff
//
// Purpose
//   Synchronous binary up counter built as a T-flip-flop chain: bit i toggles
//   when every lower bit is 1 and counting is enabled. Adds a count enable, a
//   synchronous parallel load, a programmable modulus wrap and a terminal-count
//   strobe for cascading. This is the incrementing counterpart of the T-FF down
//   counter used in timer/divider datapaths.
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   MOD_VAL  modulus; counts 0 .. MOD_VAL-1 (legal range 2 .. 2**WIDTH)
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-low reset (q -> 0 immediately)
//   en       in   1      count enable; +1 per clk edge while high
//   load     in   1      synchronous parallel load strobe (beats en)
//   d        in   WIDTH  load value; out-of-range values load 0
//   q        out  WIDTH  current count (registered)
//   qb       out  WIDTH  bitwise complement of q (combinational)
//   tc       out  1      terminal count: en & (q == MOD_VAL-1) (combinational)
//
// Optional build macro
//   UPCNT_OVF_FLAG_EN  adds
//     ovf_clr  in   1    synchronous clear of the overflow flag
//     ovf      out  1    registered sticky flag; sets on every wrap edge
//                        (tc=1 and load=0). A wrap on the same edge as
//                        ovf_clr leaves the flag set.
//   Without the macro the ports and the flag logic are absent.
//
// Cascading
//   Feed tc of stage n into en of stage n+1. tc is high exactly during the
//   cycle whose edge wraps the stage, so the upper stage steps on that same
//   edge with no added latency.
// ---------------------------------------------------------------------------
module sync_up_counter_tff #(
  parameter int WIDTH   = 3,
  parameter int MOD_VAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`ifdef UPCNT_OVF_FLAG_EN
  input  logic             ovf_clr,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  // Highest legal count. MOD_VAL-1 always fits in WIDTH bits for a legal
  // MOD_VAL, so every comparison below stays WIDTH bits wide, including the
  // full-range case MOD_VAL == 2**WIDTH.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD_VAL - 1);

  logic [WIDTH-1:0] t;        // per-bit toggle terms of the T-FF chain
  logic             at_last;  // q is the final count before wrap
  logic             wrap;     // this edge takes q from LAST back to 0
  logic [WIDTH-1:0] q_next;

  // Toggle chain: T[0] = 1, T[i] = &q[i-1:0], built as a ripple AND so each
  // stage reuses the previous term.
  always_comb begin
    t    = '0;
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & q[i-1];
    end
  end

  assign at_last = (q == LAST);
  assign tc      = en & at_last;
  // load has priority over counting, so a loaded edge is never a wrap even
  // if tc is high in that cycle.
  assign wrap    = tc & ~load;

  // Next-state selection: load > en > hold. For a full-range modulus the
  // toggle chain already rolls all-ones over to zero; the explicit clear on
  // at_last covers shorter moduli where the chain alone would overshoot.
  always_comb begin
    q_next = q;
    if (load) begin
      // Clamping illegal load values to 0 keeps q < MOD_VAL under any input.
      q_next = (d <= LAST) ? d : '0;
    end else if (en) begin
      q_next = at_last ? '0 : (q ^ t);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  assign qb = ~q;

`ifdef UPCNT_OVF_FLAG_EN
  // Sticky overflow flag. Set is checked first so a wrap coinciding with a
  // clear request is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (wrap) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  // wrap only feeds the overflow flag; keep it referenced in this build.
  logic unused_wrap;
  assign unused_wrap = wrap;
`endif

endmodule

// File: tb/tb_sync_up_counter_tff.sv
// ---------------------------------------------------------------------------
// tb_sync_up_counter_tff
//
// Directed bench for sync_up_counter_tff. Four instances share one clock and
// reset:
//   u_dut8  WIDTH=3 MOD_VAL=8  (reset, load, enable behaviour, overflow flag)
//   u_dut6  WIDTH=3 MOD_VAL=6  (short-modulus wrap and load clamping)
//   u_lo/u_hi  WIDTH=3 MOD_VAL=8 cascaded through tc_lo -> en of u_hi
// Inputs change 1 time unit after a rising edge; outputs are checked there,
// well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_sync_up_counter_tff;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // u_dut8
  logic       en8 = 1'b0, load8 = 1'b0;
  logic [2:0] d8 = '0, q8, qb8;
  logic       tc8;
`ifdef UPCNT_OVF_FLAG_EN
  logic       ovf_clr8 = 1'b0;
  logic       ovf8;
`endif

  // u_dut6
  logic       en6 = 1'b0, load6 = 1'b0;
  logic [2:0] d6 = '0, q6, qb6;
  logic       tc6;

  // cascade
  logic       en_c = 1'b0;
  logic [2:0] q_lo, qb_lo, q_hi, qb_hi;
  logic       tc_lo, tc_hi;
`ifdef UPCNT_OVF_FLAG_EN
  logic       ovf_lo, ovf_hi;
`endif

  int total = 0;
  int bad   = 0;

  sync_up_counter_tff #(.WIDTH(3), .MOD_VAL(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .load(load8), .d(d8),
`ifdef UPCNT_OVF_FLAG_EN
    .ovf_clr(ovf_clr8), .ovf(ovf8),
`endif
    .q(q8), .qb(qb8), .tc(tc8)
  );

  sync_up_counter_tff #(.WIDTH(3), .MOD_VAL(6)) u_dut6 (
    .clk(clk), .rst(rst), .en(en6), .load(load6), .d(d6),
`ifdef UPCNT_OVF_FLAG_EN
    .ovf_clr(1'b0), .ovf(),
`endif
    .q(q6), .qb(qb6), .tc(tc6)
  );

  sync_up_counter_tff #(.WIDTH(3), .MOD_VAL(8)) u_lo (
    .clk(clk), .rst(rst), .en(en_c), .load(1'b0), .d(3'd0),
`ifdef UPCNT_OVF_FLAG_EN
    .ovf_clr(1'b0), .ovf(ovf_lo),
`endif
    .q(q_lo), .qb(qb_lo), .tc(tc_lo)
  );

  sync_up_counter_tff #(.WIDTH(3), .MOD_VAL(8)) u_hi (
    .clk(clk), .rst(rst), .en(tc_lo), .load(1'b0), .d(3'd0),
`ifdef UPCNT_OVF_FLAG_EN
    .ovf_clr(1'b0), .ovf(ovf_hi),
`endif
    .q(q_hi), .qb(qb_hi), .tc(tc_hi)
  );

  // driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin : stimulus
    logic [2:0] exp_q;
    logic [2:0] exp_lo;
    logic [2:0] exp_hi;
    logic [2:0] seq6 [7];
    logic [2:0] seq_en4 [4];
    logic       en_pat [4];

    // ---- reset state ----
    #2;
    check("rst_q8",   {5'd0, q8},  8'd0);
    check("rst_qb8",  {5'd0, qb8}, 8'd7);
    check("rst_tc8",  {7'd0, tc8}, 8'd0);
    check("rst_q6",   {5'd0, q6},  8'd0);
    tick();
    rst = 1'b1;
    tick();
    check("idle_q8", {5'd0, q8}, 8'd0);

    // ---- test 1: async reset mid-count, then 1..7,0 ----
    en8 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("cnt_to5", {5'd0, q8}, 8'(i));
    end
    #2 rst = 1'b0;
    #1;
    check("async_rst_q8",  {5'd0, q8},  8'd0);
    check("async_rst_qb8", {5'd0, qb8}, 8'd7);
    tick();
    check("rst_hold_q8", {5'd0, q8}, 8'd0);
    rst = 1'b1;
    exp_q = 3'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_q = (exp_q == 3'd7) ? 3'd0 : exp_q + 3'd1;
      check("post_rst_q8",  {5'd0, q8},  {5'd0, exp_q});
      check("post_rst_tc8", {7'd0, tc8}, {7'd0, (exp_q == 3'd7)});
    end
    // last value above is 0 after the 7 -> 0 wrap

    // ---- test 3: load priority and clamping ----
    en8 = 1'b0; load8 = 1'b1; d8 = 3'd2;
    tick();
    check("load2_q8", {5'd0, q8}, 8'd2);
    en8 = 1'b1; d8 = 3'd4;
    tick();
    check("load4_over_en", {5'd0, q8}, 8'd4);
    d8 = 3'd7;
    tick();
    check("load7_q8", {5'd0, q8}, 8'd7);
    check("tc_during_load", {7'd0, tc8}, 8'd1);
    d8 = 3'd1;
    tick();
    check("load_beats_wrap", {5'd0, q8}, 8'd1);
    load8 = 1'b0; en8 = 1'b0;

    load6 = 1'b1; d6 = 3'd7;
    tick();
    check("load7_mod6_clamp", {5'd0, q6}, 8'd0);
    d6 = 3'd6;
    tick();
    check("load6_mod6_clamp", {5'd0, q6}, 8'd0);
    d6 = 3'd5;
    tick();
    check("load5_mod6", {5'd0, q6}, 8'd5);
    d6 = 3'd0;
    tick();
    check("load0_mod6", {5'd0, q6}, 8'd0);
    load6 = 1'b0;

    // ---- test 2: MOD_VAL=6 sequence ----
    seq6 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    en6 = 1'b1;
    check("tc6_at0", {7'd0, tc6}, 8'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("mod6_q",  {5'd0, q6},  {5'd0, seq6[i]});
      check("mod6_tc", {7'd0, tc6}, {7'd0, (seq6[i] == 3'd5)});
    end
    en6 = 1'b0;
    tick();
    check("mod6_hold", {5'd0, q6}, 8'd1);

    // ---- test 4: enable pattern from q=3 ----
    load8 = 1'b1; d8 = 3'd3;
    tick();
    load8 = 1'b0;
    check("load3_q8", {5'd0, q8}, 8'd3);
    en_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    seq_en4 = '{3'd4, 3'd4, 3'd4, 3'd5};
    for (int i = 0; i < 4; i++) begin
      en8 = en_pat[i];
      tick();
      check("en_pat_q8",  {5'd0, q8},  {5'd0, seq_en4[i]});
      check("en_pat_qb8", {5'd0, qb8}, {5'd0, ~seq_en4[i]});
    end
    en8 = 1'b0;

    // ---- test 5: cascade, 64 edges ----
    exp_lo = 3'd0;
    exp_hi = 3'd0;
    check("casc_lo_start", {5'd0, q_lo}, 8'd0);
    check("casc_hi_start", {5'd0, q_hi}, 8'd0);
    en_c = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (exp_lo == 3'd7) exp_hi = exp_hi + 3'd1;
      exp_lo = exp_lo + 3'd1;
      check("casc_lo", {5'd0, q_lo}, {5'd0, exp_lo});
      check("casc_hi", {5'd0, q_hi}, {5'd0, exp_hi});
    end
    en_c = 1'b0;
    check("casc_lo_end", {5'd0, q_lo}, 8'd0);
    check("casc_hi_end", {5'd0, q_hi}, 8'd0);

`ifdef UPCNT_OVF_FLAG_EN
    // ---- test 6: overflow flag ----
    ovf_clr8 = 1'b1;
    tick();
    ovf_clr8 = 1'b0;
    check("ovf_cleared", {7'd0, ovf8}, 8'd0);
    load8 = 1'b1; d8 = 3'd7;
    tick();
    load8 = 1'b0;
    check("ovf_no_set_on_load", {7'd0, ovf8}, 8'd0);
    en8 = 1'b1;
    tick();
    en8 = 1'b0;
    check("ovf_wrap_q", {5'd0, q8}, 8'd0);
    check("ovf_set",    {7'd0, ovf8}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovf_sticky", {7'd0, ovf8}, 8'd1);
    end
    ovf_clr8 = 1'b1;
    tick();
    ovf_clr8 = 1'b0;
    check("ovf_clr", {7'd0, ovf8}, 8'd0);
    load8 = 1'b1; d8 = 3'd7;
    tick();
    load8 = 1'b0;
    en8 = 1'b1; ovf_clr8 = 1'b1;
    tick();
    en8 = 1'b0; ovf_clr8 = 1'b0;
    check("ovf_set_wins_q", {5'd0, q8}, 8'd0);
    check("ovf_set_wins",   {7'd0, ovf8}, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
